// File: rtl/spiker_adapter_pkg.sv
// Shared definitions for the spiker adapter: size derivations and wrap FSM states.
package spiker_adapter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } spiker_wrap_state_e;

    // Spike vector width rounded up to a whole number of register words.
    function automatic int unsigned calc_data_width(input int unsigned n_spikes,
                                                    input int unsigned width);
        return ((n_spikes + width - 1) / width) * width;
    endfunction

    // Number of register words needed to hold one spike vector.
    function automatic int unsigned calc_n_words(input int unsigned n_spikes,
                                                 input int unsigned width);
        return calc_data_width(n_spikes, width) / width;
    endfunction

    // Word index width; a single-word result still gets a 1-bit index.
    function automatic int unsigned calc_idx_w(input int unsigned n_spikes,
                                               input int unsigned width);
        int unsigned nw;
        nw = calc_n_words(n_spikes, width);
        return (nw <= 1) ? 1 : $clog2(nw);
    endfunction

endpackage

// File: rtl/spiker_wrap_if.sv
// Spike-result handshake plus register-file write strobes of spiker_wrap.
interface spiker_wrap_if
    import spiker_adapter_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_SPIKES = 784
) ();

    localparam int unsigned IDX_W = calc_idx_w(N_SPIKES, WIDTH);

    logic                spikes_valid_i;
    logic                spikes_ready_o;
    logic [N_SPIKES-1:0] spikes_i;
    logic                reg_stall_i;
    logic [IDX_W-1:0]    word_idx_o;
    logic [WIDTH-1:0]    word_data_o;
    logic                word_we_o;
    logic                busy_o;
    logic                done_o;
    logic                clear_i;

    // Block-side view.
    modport slave (
        input  spikes_valid_i, spikes_i, reg_stall_i, clear_i,
        output spikes_ready_o, word_idx_o, word_data_o, word_we_o, busy_o, done_o
    );

    // Spike core / register file / software side.
    modport master (
        output spikes_valid_i, spikes_i, reg_stall_i, clear_i,
        input  spikes_ready_o, word_idx_o, word_data_o, word_we_o, busy_o, done_o
    );

endinterface

// File: rtl/spiker_wrap.sv
// Captures a spike result vector and writes it word by word into the
// result register array; raises a sticky done flag when the last word lands.
module spiker_wrap
    import spiker_adapter_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_SPIKES = 784
) (
    input logic          clk_i,
    input logic          rst_i,
    spiker_wrap_if.slave bus
);

    localparam int unsigned DATA_WIDTH = calc_data_width(N_SPIKES, WIDTH);
    localparam int unsigned N_WORDS    = calc_n_words(N_SPIKES, WIDTH);
    localparam int unsigned IDX_W      = calc_idx_w(N_SPIKES, WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    spiker_wrap_state_e    state_q;
    logic [DATA_WIDTH-1:0] shadow_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  done_q;

    // Capture, word stepping and sticky done; a completing write beats clear_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            if (bus.clear_i) begin
                done_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (bus.spikes_valid_i) begin
                        shadow_q <= DATA_WIDTH'(bus.spikes_i);
                        idx_q    <= '0;
                        done_q   <= 1'b0;
                        state_q  <= WRITE;
                    end
                end
                WRITE: begin
                    if (!bus.reg_stall_i) begin
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake, status and the word currently presented to the register file.
    always_comb begin
        bus.spikes_ready_o = (state_q == IDLE);
        bus.busy_o         = (state_q == WRITE);
        bus.word_we_o      = (state_q == WRITE) && !bus.reg_stall_i;
        bus.word_idx_o     = idx_q;
        bus.word_data_o    = shadow_q[idx_q * WIDTH +: WIDTH];
        bus.done_o         = done_q;
    end

endmodule
